// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   cnt_w()   : bit counter width for a given operand width
//   PIN_*     : bit positions of the packed io_in / io_out pins
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // io_in bit assignments
  localparam int PIN_CLK     = 0;
  localparam int PIN_RST     = 1;
  localparam int PIN_A_BIT   = 2;
  localparam int PIN_B_BIT   = 3;
  localparam int PIN_START   = 4;
  localparam int PIN_NIB_SEL = 5;
  localparam int PIN_CLEAR   = 6;
  localparam int PIN_ACC     = 7;

  // io_out bit assignments
  localparam int PIN_BUSY    = 0;
  localparam int PIN_DONE    = 1;
  localparam int PIN_SUM     = 2;
  localparam int PIN_OVF     = 3;
  localparam int PIN_NIB_LO  = 4;

  // One spare bit so the counter can represent WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_seq_full_adder.sv
// 1-bit full-adder cell.
//   a_i, b_i, cin_i : operand bits and carry in
//   sum_o, cout_o   : sum bit and carry out (majority)
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer. One operand bit pair per clock, LSB first,
// through a single full-adder cell; carry is registered back into cin and
// sum bits shift into a WIDTH-bit result register. In accumulate mode
// operand A is taken from the result register's LSB, which is exactly the
// previous result's bit k on the k-th RUN edge because the register shifts.
//   io_in  : [0] clk, [1] rst (async, active-high), [2] a_bit, [3] b_bit,
//            [4] start, [5] nib_sel, [6] clear, [7] acc_mode
//   io_out : [0] busy, [1] done, [2] sum_bit, [3] overflow, [7:4] nibble
//
// state | meaning
// IDLE  | waiting for start; clear zeroes result/overflow
// RUN   | consuming one operand bit pair per edge
// DONE  | result held; waits for start=0 before returning to IDLE
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic clk;
  logic rst;
  logic a_bit;
  logic b_bit;
  logic start;
  logic nib_sel;
  logic clear;
  logic acc_mode;

  assign clk      = io_in[PIN_CLK];
  assign rst      = io_in[PIN_RST];
  assign a_bit    = io_in[PIN_A_BIT];
  assign b_bit    = io_in[PIN_B_BIT];
  assign start    = io_in[PIN_START];
  assign nib_sel  = io_in[PIN_NIB_SEL];
  assign clear    = io_in[PIN_CLEAR];
  assign acc_mode = io_in[PIN_ACC];

  state_t             state_q;
  logic               carry_q;
  logic               overflow_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_d;
  logic [CNT_W-1:0]   bit_cnt_q;

  logic fa_a;
  logic fa_sum;
  logic fa_cout;
  logic last_bit;

  assign fa_a = acc_mode ? result_q[0] : a_bit;

  full_adder_bit u_fa (
    .a_i    (fa_a),
    .b_i    (b_bit),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  assign result_d = {fa_sum, result_q[WIDTH-1:1]};
  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      result_q   <= '0;
      bit_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // clear has priority over start
          if (clear) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
          end else if (start) begin
            state_q   <= RUN;
            carry_q   <= 1'b0;
            bit_cnt_q <= '0;
          end
        end
        RUN: begin
          result_q  <= result_d;
          carry_q   <= fa_cout;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (last_bit) begin
            overflow_q <= fa_cout;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (clear) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
          end
          if (!start) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Display: result zero-extended to 8 bits, one nibble at a time.
  logic [7:0] result_ext;
  logic [3:0] nibble;

  always_comb begin
    result_ext              = '0;
    result_ext[WIDTH-1:0]   = result_q;
  end

  assign nibble = nib_sel ? result_ext[7:4] : result_ext[3:0];

  always_comb begin
    io_out              = '0;
    io_out[PIN_BUSY]    = (state_q == RUN);
    io_out[PIN_DONE]    = (state_q == DONE);
    io_out[PIN_SUM]     = (state_q == RUN) & fa_sum;
    io_out[PIN_OVF]     = overflow_q;
    io_out[7:PIN_NIB_LO] = nibble;
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
module tb_serial_adder_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_bit = 1'b0;
  logic       b_bit = 1'b0;
  logic       start = 1'b0;
  logic       nib_sel = 1'b0;
  logic       clear = 1'b0;
  logic       acc_mode = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int n_chk  = 0;
  int n_fail = 0;

  // reference state: last completed result and overflow
  logic [7:0] mdl_res = 8'h00;
  logic       mdl_ovf = 1'b0;

  assign io_in = {acc_mode, clear, nib_sel, start, b_bit, a_bit, rst, clk};

  serial_adder_seq #(.WIDTH(8)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // read the full result through the nibble mux (inside a low clock phase)
  task automatic read_result(output logic [7:0] r);
    nib_sel = 1'b0;
    #1 r[3:0] = io_out[7:4];
    nib_sel = 1'b1;
    #1 r[7:4] = io_out[7:4];
    nib_sel = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_outputs", {8'h00, io_out}, 16'h0000);
    #1 rst = 1'b0;
    mdl_res = 8'h00;
    mdl_ovf = 1'b0;
  endtask

  // One full add. clr_bit >= 0 pulses clear during that RUN bit (must be ignored).
  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic acc,
                         input int clr_bit, input int hold_cycles);
    logic [8:0] sum;
    logic [7:0] opa;
    logic [7:0] r;
    @(negedge clk);
    start    = 1'b1;
    acc_mode = acc;
    a_bit    = 1'b0;
    b_bit    = 1'b0;
    @(posedge clk);
    opa = acc ? mdl_res : a;
    sum = {1'b0, opa} + {1'b0, b};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_bit = a[k];
      b_bit = b[k];
      clear = (k == clr_bit);
      #1;
      chk("busy_in_run", {15'd0, io_out[0]}, 16'd1);
      chk("sum_bit", {15'd0, io_out[2]}, {15'd0, sum[k]});
      @(posedge clk);
    end
    @(negedge clk);
    clear = 1'b0;
    mdl_res = sum[7:0];
    mdl_ovf = sum[8];
    #1;
    chk("done_flag", {14'd0, io_out[1:0]}, 16'd2);
    chk("overflow", {15'd0, io_out[3]}, {15'd0, mdl_ovf});
    chk("sum_bit_idle", {15'd0, io_out[2]}, 16'd0);
    read_result(r);
    chk("result", {8'd0, r}, {8'd0, mdl_res});
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      #1 chk("done_hold", {14'd0, io_out[1:0]}, 16'd2);
    end
    @(negedge clk);
    start    = 1'b0;
    acc_mode = 1'b0;
    @(negedge clk);
    #1 chk("back_to_idle", {14'd0, io_out[1:0]}, 16'd0);
    read_result(r);
    chk("result_held", {8'd0, r}, {8'd0, mdl_res});
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1;
    #1;
    chk("power_on_reset", {8'h00, io_out}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // 0x5A + 0x3C -> 0x96
    run_add(8'h5A, 8'h3C, 1'b0, -1, 0);
    nib_sel = 1'b0;
    #1 chk("nib_lo", {12'd0, io_out[7:4]}, 16'h6);
    nib_sel = 1'b1;
    #1 chk("nib_hi", {12'd0, io_out[7:4]}, 16'h9);
    nib_sel = 1'b0;

    // wrap with start held in DONE
    run_add(8'hFF, 8'h01, 1'b0, -1, 4);
    chk("wrap_result", {8'd0, mdl_res}, 16'h0000);

    // accumulate sequence
    run_add(8'h5A, 8'h3C, 1'b0, -1, 0);
    run_add(8'h00, 8'h10, 1'b1, -1, 0);
    chk("acc_a6", {7'd0, mdl_ovf, mdl_res}, 16'h00A6);
    run_add(8'hFF, 8'h60, 1'b1, -1, 0);
    chk("acc_wrap", {7'd0, mdl_ovf, mdl_res}, 16'h0106);

    // asynchronous reset after 3 RUN edges
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_bit = 1'(8'h5A >> k);
      b_bit = 1'(8'h3C >> k);
      @(posedge clk);
    end
    @(negedge clk);
    #1 chk("busy_before_rst", {15'd0, io_out[0]}, 16'd1);
    #1 rst = 1'b1;
    #1 chk("async_reset", {8'h00, io_out}, 16'h0000);
    #1 rst = 1'b0;
    start = 1'b0;
    mdl_res = 8'h00;
    mdl_ovf = 1'b0;
    run_add(8'h01, 8'h02, 1'b0, -1, 0);

    // clear + start together in IDLE
    run_add(8'h5A, 8'h3C, 1'b0, -1, 0);
    run_add(8'h00, 8'h10, 1'b1, -1, 0);
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    #1 chk("clr_start_idle", {14'd0, io_out[1:0]}, 16'd0);
    chk("clr_ovf", {15'd0, io_out[3]}, 16'd0);
    read_result(r);
    chk("clr_result", {8'd0, r}, 16'h0000);
    clear = 1'b0;
    start = 1'b0;
    mdl_res = 8'h00;
    mdl_ovf = 1'b0;

    // clear pulse in RUN is ignored
    run_add(8'h11, 8'h22, 1'b0, 3, 0);
    chk("clr_in_run", {8'd0, mdl_res}, 16'h0033);

    // randomized adds against the arithmetic model
    for (int t = 0; t < 24; t++) begin
      run_add(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
              int'($urandom_range(0, 2)));
    end

    // clear in DONE zeroes result but stays DONE while start is high
    run_add(8'h80, 8'h80, 1'b0, -1, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_bit = 1'b1;
      b_bit = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    #1 chk("done_pre_clear", {15'd0, io_out[3]}, 16'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1 chk("done_after_clear", {14'd0, io_out[1:0]}, 16'd2);
    chk("ovf_cleared", {15'd0, io_out[3]}, 16'd0);
    read_result(r);
    chk("res_cleared", {8'd0, r}, 16'h0000);
    start = 1'b0;
    @(negedge clk);
    #1 chk("idle_after_clear", {14'd0, io_out[1:0]}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial adder sequencer built around the team's 1-bit full-adder cell (a, b, cin -> sum, cout).
- Feeds that cell one operand bit pair per clock, LSB first, and registers the carry back into cin.
- Collects sum bits into a WIDTH-bit result shift register.
- Optional accumulate mode takes operand A from the previous result, turning the cell into a serial accumulator; result is shown on output pins one nibble at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; legal 4..8; result zero-extended to 8 bits for display.

Ports:
- io_in[0]  input  1  clock; all state updates on its rising edge.
- io_in[1]  input  1  reset; asynchronous, active-high.
- io_in[2]  input  1  a_bit: serial operand A bit, ignored when acc_mode=1.
- io_in[3]  input  1  b_bit: serial operand B bit.
- io_in[4]  input  1  start: level request to begin an add.
- io_in[5]  input  1  nib_sel: 0 shows result[3:0], 1 shows result[7:4].
- io_in[6]  input  1  clear: synchronous clear of result and overflow.
- io_in[7]  input  1  acc_mode: 1 = operand A is the current result register.
- io_out[0] output 1  busy: high in RUN.
- io_out[1] output 1  done: high in DONE.
- io_out[2] output 1  sum_bit: combinational sum of the current full-adder inputs, valid in RUN.
- io_out[3] output 1  overflow: final carry of the last completed add.
- io_out[7:4] output 4  result nibble selected by nib_sel.

Behaviour:
- Reset values: state=IDLE, result=0, carry=0, overflow=0, bit_cnt=0. All outputs read 0.
- Reset mid-operation aborts immediately with the same values; there is no partial result.
- States: IDLE, RUN, DONE.
- IDLE:
  - clear=1 zeroes result and overflow.
  - Otherwise, start=1 at a rising edge moves to RUN with carry=0, bit_cnt=0.
  - If clear and start are both high, clear wins and the state stays IDLE.
- RUN, each edge:
  - a = acc_mode ? result[0] : a_bit
  - s = a^b_bit^carry
  - carry <= maj(a, b_bit, carry)
  - result <= {s, result[WIDTH-1:1]}
  - bit_cnt <= bit_cnt+1
- Operand bit k is sampled on the (k+1)th rising edge after the edge that entered RUN.
- On the edge that consumes bit WIDTH-1: overflow <= final carry out, state -> DONE.
  - Latency is WIDTH edges from RUN entry to DONE.
- In RUN, start, clear and nib_sel changes have no effect on sequencing. acc_mode is sampled every edge; toggling it mid-run is legal but mixes sources.
- DONE:
  - done=1; result and overflow hold.
  - Moves to IDLE only when start=0 (four-phase handshake). start held high never retriggers.
  - clear=1 in DONE zeroes result/overflow and stays in DONE until start=0.
- Wrap-around: the sum is modulo 2^WIDTH; the carry out goes only to overflow.
- Accumulate wrap: 0xFF+0x01 in acc_mode gives result 0x00, overflow=1.
- sum_bit is 0 outside RUN.
- Display: io_out[7:4] is purely combinational from result and nib_sel.
  - For WIDTH<8, bits at or above WIDTH read 0.

Decomposition:
- Package serial_adder_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - CNT_W = $clog2(WIDTH)+1.
  - Pin index constants for io_in/io_out bit assignments.
- Sub-module full_adder_bit (combinational a, b, cin -> sum, cout), reused from the team's adder cell.
- The top holds only the FSM, carry flop, counter, result shifter and display mux.

Test Plan:
- Reset, then start with a=0x5A, b=0x3C LSB first over 8 edges -> busy for 8 cycles, then done=1, result 0x96, overflow=0; nib_sel=0 shows 6, nib_sel=1 shows 9.
- a=0xFF, b=0x01 -> result 0x00, overflow=1; hold start high in DONE -> remains DONE, no second run. Drop start -> IDLE next edge.
- After result=0x96, acc_mode=1 with b=0x10 -> result 0xA6, overflow=0. A second run with b=0x60 -> 0x06, overflow=1.
- Assert reset asynchronously after 3 RUN edges of a 0x5A+0x3C add -> all outputs 0 without waiting for a clock edge. The next full add of 0x01+0x02 gives 0x03.
- In IDLE with result=0xA6, assert clear and start together -> result 0x00, overflow 0, state stays IDLE. In RUN, pulse clear -> ignored, and the add of 0x11+0x22 completes with 0x33.
